// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler draining VC0/VC1 FIFOs into destination FIFOs D0/D1.
// Latency: pop at edge N -> capture at N+1 -> push_d0/push_d1 + data_out at N+2 (1 word/cycle).
// Backpressure: no pop while either destination is almost full; words already in flight are always pushed.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   init                   high = hold in INIT and load thresholds from umbral_*_in
//   umbral_*_in / umbral_* threshold inputs / registered thresholds
//   empty_vc*, error_vc*   VC FIFO status (empty, overflow)
//   data_vc*               VC FIFO read data, valid the cycle after pop_vc*
//   almost_full_d*         destination back-pressure
//   pop_vc*, push_d*       FIFO read / write enables (registered)
//   data_out               word to destinations, zero when nothing is pushed
//   state                  one-hot {ERROR, ACTIVE, IDLE, INIT, RESET}
//   active_out/idle_out/error_out  registered state decodes
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int dest_bit   = 4,
    parameter int weight_vc0 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            umbral_vc0_in,
    input  logic [3:0]            umbral_vc1_in,
    input  logic [3:0]            umbral_d_in,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic                  error_vc0,
    input  logic                  error_vc1,
    input  logic [data_width-1:0] data_vc0,
    input  logic [data_width-1:0] data_vc1,
    input  logic                  almost_full_d0,
    input  logic                  almost_full_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [data_width-1:0] data_out,
    output logic [3:0]            umbral_vc0,
    output logic [3:0]            umbral_vc1,
    output logic [3:0]            umbral_d,
    output logic [4:0]            state,
    output logic                  active_out,
    output logic                  idle_out,
    output logic                  error_out
);

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    localparam logic [3:0] WEIGHT = 4'(weight_vc0);

    logic [4:0]            state_nxt;
    logic [3:0]            grant_cnt;
    logic [3:0]            grant_cnt_nxt;
    logic                  cap_vld;
    logic [data_width-1:0] cap_dat;
    logic                  err_any;
    logic                  both_empty;
    logic                  drained;
    logic                  pop_ok;
    logic                  grant_vc0;
    logic                  grant_vc1;

    always_comb begin
        err_any    = error_vc0 | error_vc1;
        both_empty = empty_vc0 & empty_vc1;
        // Nothing popped this cycle and nothing waiting in the capture stage;
        // a word sitting in the push stage leaves on its own.
        drained    = ~pop_vc0 & ~pop_vc1 & ~cap_vld;

        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (err_any)          state_nxt = ST_ERROR;
                else if (init)        state_nxt = ST_INIT;
                else if (!both_empty) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (err_any)                  state_nxt = ST_ERROR;
                else if (init)                state_nxt = ST_INIT;
                else if (both_empty && drained) state_nxt = ST_IDLE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase

        // Destination is unknown until the word is read, so either
        // almost-full flag blocks the pop.
        pop_ok = (state == ST_ACTIVE) & ~err_any & ~init
               & ~almost_full_d0 & ~almost_full_d1;

        // VC0 keeps the grant until it has used its weight, unless VC1 has
        // nothing to send.
        grant_vc0 = pop_ok & ~empty_vc0 & ((grant_cnt < WEIGHT) | empty_vc1);
        grant_vc1 = pop_ok & ~grant_vc0 & ~empty_vc1;

        grant_cnt_nxt = grant_cnt;
        if (grant_vc0 && (grant_cnt < WEIGHT)) grant_cnt_nxt = grant_cnt + 4'd1;
        if (grant_vc1)                         grant_cnt_nxt = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RESET;
            umbral_vc0 <= 4'd0;
            umbral_vc1 <= 4'd0;
            umbral_d   <= 4'd0;
            pop_vc0    <= 1'b0;
            pop_vc1    <= 1'b0;
            push_d0    <= 1'b0;
            push_d1    <= 1'b0;
            data_out   <= '0;
            cap_vld    <= 1'b0;
            cap_dat    <= '0;
            grant_cnt  <= 4'd0;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_INIT) begin
                umbral_vc0 <= umbral_vc0_in;
                umbral_vc1 <= umbral_vc1_in;
                umbral_d   <= umbral_d_in;
            end

            pop_vc0   <= grant_vc0;
            pop_vc1   <= grant_vc1;
            grant_cnt <= grant_cnt_nxt;

            // Stage 1: FIFO read data is valid the cycle after the pop.
            cap_vld <= pop_vc0 | pop_vc1;
            cap_dat <= pop_vc0 ? data_vc0 : (pop_vc1 ? data_vc1 : '0);

            // Stage 2: route by the destination bit; bus is zero when idle.
            push_d0  <= cap_vld & ~cap_dat[dest_bit];
            push_d1  <= cap_vld &  cap_dat[dest_bit];
            data_out <= cap_vld ? cap_dat : '0;

            active_out <= (state_nxt == ST_ACTIVE);
            idle_out   <= (state_nxt == ST_IDLE);
            error_out  <= (state_nxt == ST_ERROR);
        end
    end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
Transaction-layer scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1). It owns threshold configuration for the FIFOs and sequences them through RESET/INIT/IDLE/ACTIVE/ERROR. It issues FIFO pops using weighted round-robin, honours downstream almost-full back-pressure, and routes each popped word to D0 or D1 by a destination bit.

Parameters:
data_width, 6, word width of VC and destination FIFOs
dest_bit, 4, bit of a word selecting destination (0 -> D0, 1 -> D1)
weight_vc0, 3, max consecutive VC0 grants before VC1 gets one (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
init  in  1  configuration request; high = load thresholds
umbral_vc0_in  in  4  VC0 threshold to load
umbral_vc1_in  in  4  VC1 threshold to load
umbral_d_in  in  4  destination threshold to load
empty_vc0, empty_vc1  in  1 each  VC FIFO empty flags
error_vc0, error_vc1  in  1 each  VC FIFO overflow flags
data_vc0, data_vc1  in  data_width each  VC FIFO read data (valid cycle after pop, else 0)
almost_full_d0, almost_full_d1  in  1 each  destination back-pressure
pop_vc0, pop_vc1  out  1 each  VC FIFO read enables
push_d0, push_d1  out  1 each  destination write enables
data_out  out  data_width  word to destinations
umbral_vc0, umbral_vc1, umbral_d  out  4 each  registered thresholds
state  out  5  one-hot: [0]RESET [1]INIT [2]IDLE [3]ACTIVE [4]ERROR
active_out, idle_out, error_out  out  1 each  state decodes

Behaviour:
- All outputs registered. reset=1 at edge: state=RESET, thresholds=0, all pops/pushes=0, data_out=0, grant counter=0, pipeline valids cleared; overrides everything, including mid-transfer (in-flight words dropped).
- RESET -> INIT first edge with reset=0.
- INIT: umbral_* loaded from *_in every cycle; no pops. INIT -> IDLE when init=0.
- Any non-RESET state with init=1 -> INIT next edge; pops stop same edge, in-flight words still pushed.
- IDLE -> ACTIVE when empty_vc0=0 or empty_vc1=0.
- ACTIVE -> IDLE when both empty, no pop issued this cycle and pipeline drained.
- error_vc0|error_vc1 in IDLE/ACTIVE -> ERROR; sticky until reset; init ignored in ERROR; no pops.
- Priority of transitions: reset > error > init > others.
- Pop eligibility (ACTIVE only): almost_full_d0=0 and almost_full_d1=0 (destination unknown before pop); at most one pop per cycle.
- Arbitration: VC0 granted if non-empty and (count<weight_vc0 or VC1 empty); VC0 grant increments count. VC1 granted otherwise if non-empty; count reset to 0. Count saturates at weight_vc0.
- Pipeline: pop at edge N (pop_vcX high cycle N) -> capture data_vcX at edge N+1 -> push_dY and data_out valid cycle N+2, Y=data[dest_bit]. Latency 2, throughput 1 word/cycle. Exactly one push per pop.
- push_d0/d1 never both high; data_out=0 when no push.
- Back-to-back pops allowed; FIFO empty flag reflects pop one cycle later, so the block must not pop when empty is high at the evaluating edge.

Test Plan:
- reset=1 3 cycles then 0, init=1 2 cycles with umbral_vc0_in=4, vc1=3, d=2, init=0 -> state 00001->00010->00100; umbral_vc0=4, vc1=3, d=2; no pops.
- VC0 holds 5 words, VC1 holds 2, no back-pressure -> pop order VC0,VC0,VC0,VC1,VC0,VC0,VC1; each push 2 cycles after its pop; then IDLE.
- Word 6'b010101 (bit4=1) from VC1 -> push_d1=1, data_out=010101 at pop+2; word 6'b000011 -> push_d0.
- almost_full_d1=1 for 4 cycles mid-stream -> no pops those cycles; in-flight words still pushed; resume next cycle after deassert.
- error_vc1=1 during ACTIVE -> state=ERROR, error_out=1, pops stop; init=1 has no effect; reset returns RESET.
- reset=1 at cycle after pop -> no push follows, all outputs 0.
